// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - UART-fed loader that turns a length-prefixed image into program-memory word writes
module instr_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MEM_DEPTH    = 1024,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_Rx_Serial,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam int              TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]   HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]   TIMER_ONE = TW'(1);
  localparam logic [16:0]     MAX_LEN   = 17'(MEM_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, WORDS, DONE} ld_state_t;

  rx_state_t     rx_state, rx_next;
  logic          rx_meta, rx_sync;
  logic [TW-1:0] bit_timer;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          timer_hit;
  logic          byte_valid, byte_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  // timer_hit marks the sample point of the current RX phase
  always_comb begin
    rx_next   = rx_state;
    timer_hit = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) rx_next = RX_START;
      end
      RX_START: begin
        timer_hit = (bit_timer == HALF_LAST);
        if (timer_hit) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        timer_hit = (bit_timer == BIT_LAST);
        if (timer_hit && bit_idx == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP: begin
        timer_hit = (bit_timer == BIT_LAST);
        if (timer_hit) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      bit_timer  <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      if (rx_state == RX_IDLE || timer_hit) begin
        bit_timer <= '0;
      end else begin
        bit_timer <= bit_timer + TIMER_ONE;
      end
      if (rx_state == RX_IDLE) begin
        bit_idx <= '0;
      end
      if (rx_state == RX_DATA && timer_hit) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end
      if (rx_state == RX_STOP && timer_hit) begin
        byte_valid <= rx_sync;
        byte_err   <= !rx_sync;
      end
    end
  end

  ld_state_t       ld_state, ld_next;
  logic            start_q, start_edge;
  logic [7:0]      len_hi;
  logic [15:0]     word_len;
  logic [15:0]     len_rx;
  logic [15:0]     cnt_plus1;
  logic [ADDR_W:0] word_cnt;
  logic [1:0]      byte_cnt;
  logic [23:0]     asm_word;
  logic            do_write, set_err, finish;

  assign start_edge = start && !start_q;
  assign len_rx     = {len_hi, rx_shift};
  assign cnt_plus1  = 16'(word_cnt) + 16'd1;

  // a start edge overrides whatever byte event lands in the same cycle
  always_comb begin
    ld_next  = ld_state;
    do_write = 1'b0;
    set_err  = 1'b0;
    finish   = 1'b0;
    if (start_edge) begin
      ld_next = LEN_HI;
    end else begin
      case (ld_state)
        IDLE: ld_next = IDLE;
        LEN_HI: begin
          if (byte_err) begin
            set_err = 1'b1;
            ld_next = IDLE;
          end else if (byte_valid) begin
            ld_next = LEN_LO;
          end
        end
        LEN_LO: begin
          if (byte_err) begin
            set_err = 1'b1;
            ld_next = IDLE;
          end else if (byte_valid) begin
            if (len_rx == 16'd0) begin
              ld_next = DONE;
            end else if ({1'b0, len_rx} > MAX_LEN) begin
              set_err = 1'b1;
              ld_next = IDLE;
            end else begin
              ld_next = WORDS;
            end
          end
        end
        WORDS: begin
          if (byte_err) begin
            set_err = 1'b1;
            ld_next = IDLE;
          end else if (byte_valid && byte_cnt == 2'd3) begin
            do_write = 1'b1;
            if (cnt_plus1 == word_len) ld_next = DONE;
          end
        end
        DONE: begin
          finish  = 1'b1;
          ld_next = IDLE;
        end
        default: ld_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state  <= IDLE;
      start_q   <= 1'b0;
      len_hi    <= '0;
      word_len  <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      asm_word  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ld_state <= ld_next;
      start_q  <= start;
      wr_en    <= do_write;
      if (start_edge) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        frame_err <= 1'b0;
        word_cnt  <= '0;
        byte_cnt  <= '0;
      end else begin
        if (ld_state == LEN_HI && byte_valid) len_hi <= rx_shift;
        if (ld_state == LEN_LO && byte_valid) word_len <= len_rx;
        if (ld_state == WORDS && byte_valid) begin
          asm_word <= {asm_word[15:0], rx_shift};
          byte_cnt <= byte_cnt + 2'd1;
        end
        if (do_write) begin
          wr_addr  <= word_cnt[ADDR_W-1:0];
          wr_data  <= {asm_word, rx_shift};
          word_cnt <= word_cnt + CNT_ONE;
        end
        if (set_err) begin
          frame_err <= 1'b1;
          busy      <= 1'b0;
        end
        if (finish) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

UART-driven instruction loader that sits directly upstream of the program memory. After a `start` pulse it receives a length-prefixed binary image over a serial line and assembles the bytes into 32-bit instruction words. It emits each word as a one-cycle write strobe with a word address and data. This is the path by which a host fills instruction memory before the CPU runs.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `MEM_DEPTH`, 1024: maximum words accepted.
- `ADDR_W`, 10: width of `wr_addr`; 2^ADDR_W ≥ MEM_DEPTH.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_Rx_Serial`  in  1  UART RX line (idle high, 8N1, LSB first); asynchronous to `clk`.
- `start`  in  1  begin a load; rising-edge detected.
- `wr_en`  out  1  one-cycle write strobe to program memory.
- `wr_addr`  out  ADDR_W  word index of `wr_data`.
- `wr_data`  out  32  assembled instruction word.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed; held until the next `start` edge.
- `frame_err`  out  1  sticky; the last load aborted on a bad stop bit or an oversize length.

## Operation
- RX front end:
  - 2-FF synchronizer on `i_Rx_Serial`.
  - RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE → RX_START on a synchronized low.
  - RX_START re-samples at CLKS_PER_BIT/2. If the line is high, it is a glitch; return to RX_IDLE. If low, go to RX_DATA.
  - RX_DATA samples 8 bits, one every CLKS_PER_BIT, LSB first.
  - RX_STOP samples once at CLKS_PER_BIT. If the sample is 1, a 1-cycle internal `byte_valid` fires with the byte. If 0, a 1-cycle `byte_err` fires.
  - RX_STOP then returns to RX_IDLE.
- Load FSM states: IDLE, LEN_HI, LEN_LO, WORDS, DONE.
  - IDLE: received bytes are discarded. A `start` rising edge → LEN_HI; this also clears `done`, `frame_err`, the word counter and the byte counter.
  - LEN_HI/LEN_LO: the 16-bit word count N is sent big-endian.
    - N = 0 → DONE, with no writes.
    - N > MEM_DEPTH → set `frame_err`, go to IDLE.
    - Otherwise → WORDS.
  - WORDS: each word arrives as 4 bytes, MSB first, shifted into a 32-bit assembler.
    - On the 4th byte: `wr_en`=1 for one cycle, with `wr_data` = the word and `wr_addr` = the word counter (starting at 0). The word counter then increments.
    - After the write with counter = N−1 → DONE.
  - DONE: `done`=1, `busy`=0, then → IDLE.
- `busy`=1 in LEN_HI, LEN_LO and WORDS.
- `byte_err` during LEN_HI, LEN_LO or WORDS: set `frame_err`, go to IDLE, no further writes; a partially assembled word is dropped.
- A `start` edge while busy restarts the load at LEN_HI; already written words are not retracted.
- If a `start` edge and a `byte_valid` land in the same cycle, the restart wins and the byte is discarded.

## Timing
- All outputs reset to 0: `wr_en`, `wr_addr`, `wr_data`, `busy`, `done`, `frame_err`.
- `rst` mid-load aborts immediately; the RX FSM and load FSM return to RX_IDLE/IDLE.
- `wr_en` is asserted on the clock edge following the `byte_valid` of the 4th byte of a word.
- `wr_addr` and `wr_data` are valid only while `wr_en`=1, and are held until the next write.
- `done` rises on the cycle after the last `wr_en`; with N=0, it rises 1 cycle after LEN_LO.
- `busy` falls on the same edge on which `done` rises.
- Minimum `start` pulse: 1 cycle. Edge detection uses the registered previous value.
- Byte reception latency, from the start-bit falling edge to `byte_valid`: 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles, ±1.
- Counters:
  - Bit-timer width is ceil(log2(CLKS_PER_BIT)).
  - The word counter is ADDR_W+1 bits wide, so a count of N = MEM_DEPTH does not wrap.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Basic load: `start`, then bytes 00 02 DE AD BE EF 01 23 45 67 → two `wr_en` pulses: (addr 0, 0xDEADBEEF), then (addr 1, 0x01234567); `done`=1, `busy`=0, `frame_err`=0.
- Bad stop bit: `start`, 00 01 DE AD, then a byte with its stop bit driven low → `frame_err`=1, no `wr_en`, `busy`=0, `done`=0; later bytes are ignored.
- Edge cases:
  - Length 0x0000 → `done`=1 with no `wr_en`.
  - Length 0x0401 with MEM_DEPTH=1024 → `frame_err`=1, state IDLE.
- Restart and ignore:
  - `start` after 2 of 4 bytes, then 00 01 11 22 33 44 → a single write (addr 0, 0x11223344).
  - Bytes sent before any `start` → no `wr_en`.
- Glitch and reset:
  - A 1-cycle low on `i_Rx_Serial` → no byte received.
  - `rst` asserted mid-word → all outputs 0 on the same cycle. A new full load afterwards succeeds from addr 0.
